// File: rtl/onchip_arb_pkg.sv
// Shared types and defaults for the two-master on-chip RAM arbiter.
package onchip_arb_pkg;

  localparam int unsigned DefaultAddrW = 11;
  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultBeW   = DefaultDataW / 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } gnt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant: lone requester wins; on a tie, round-robin against the
// last winner or fixed priority to A.
module rr_arb2
  import onchip_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  gnt_t last_gnt,
  input  logic rr_en,
  output gnt_t gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (req_a && req_b) begin
      gnt = (rr_en && (last_gnt == GNT_A)) ? GNT_B : GNT_A;
    end else if (req_a) begin
      gnt = GNT_A;
    end else if (req_b) begin
      gnt = GNT_B;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM masters with a per-cycle
// grant and in-order one-cycle read return.
module onchip_mem_arbiter
  import onchip_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W = DefaultAddrW,
  parameter  int unsigned DATA_W = DefaultDataW,
  parameter  int unsigned RR_EN  = 1,
  localparam int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,

  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic ready_q;
  gnt_t last_gnt_q, last_gnt_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_b_q, rd_owner_b_d;

  logic req_a, req_b;
  gnt_t arb_gnt, gnt;
  logic issue, sel_b, sel_write, rd_issue;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  rr_arb2 u_rr_arb2 (
    .req_a    (req_a),
    .req_b    (req_b),
    .last_gnt (last_gnt_q),
    .rr_en    (RR_EN != 0),
    .gnt      (arb_gnt)
  );

  // Nothing is granted until one edge after reset release.
  assign gnt   = ready_q ? arb_gnt : GNT_NONE;
  assign issue = (gnt != GNT_NONE);
  assign sel_b = (gnt == GNT_B);

  // read&write together is handled as a write.
  assign sel_write = sel_b ? b_write : a_write;
  assign rd_issue  = issue & ~sel_write;

  always_comb begin
    mem_address    = sel_b ? b_address   : a_address;
    mem_writedata  = sel_b ? b_writedata : a_writedata;
    mem_byteenable = sel_write ? (sel_b ? b_byteenable : a_byteenable) : {BE_W{1'b1}};
    mem_chipselect = issue;
    mem_write      = issue & sel_write;
    mem_clken      = ready_q;
  end

  always_comb begin
    last_gnt_d   = issue ? gnt : last_gnt_q;
    rd_pend_d    = rd_issue;
    rd_owner_b_d = rd_issue ? sel_b : rd_owner_b_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q      <= 1'b0;
      last_gnt_q   <= GNT_B;
      rd_pend_q    <= 1'b0;
      rd_owner_b_q <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      last_gnt_q   <= last_gnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_b_q <= rd_owner_b_d;
    end
  end

  always_comb begin
    a_waitrequest   = ~ready_q | (req_a & (gnt != GNT_A));
    b_waitrequest   = ~ready_q | (req_b & (gnt != GNT_B));
    a_readdata      = mem_readdata;
    b_readdata      = mem_readdata;
    a_readdatavalid = rd_pend_q & ~rd_owner_b_q;
    b_readdatavalid = rd_pend_q &  rd_owner_b_q;
  end

endmodule
